// File: rtl/code_data_path_pkg.sv
// code_data_path_pkg: opcodes, instruction field helpers and fetch-to-decode record
package code_data_path_pkg;
  localparam int INSTR_W = 12;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_DENSE = 4'h1;
  localparam logic [3:0] OP_COST = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef struct packed {
    logic [31:0] code_index;
    logic [INSTR_W-1:0] instr;
  } f2d_t;
  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] i);
    return i[11:8];
  endfunction
  function automatic logic [3:0] instr_hi(input logic [INSTR_W-1:0] i);
    return i[7:4];
  endfunction
  function automatic logic [3:0] instr_lo(input logic [INSTR_W-1:0] i);
    return i[3:0];
  endfunction
  function automatic logic [7:0] instr_byte(input logic [INSTR_W-1:0] i);
    return i[7:0];
  endfunction
endpackage

// File: rtl/code_data_path_if.sv
// code_data_path_if: host write/control inputs and decoded instruction outputs
interface code_data_path_if;
  import code_data_path_pkg::*;
  logic code_storage_write_interface_is_write;
  logic [31:0] code_storage_write_interface_write_line;
  logic [INSTR_W-1:0] code_storage_write_interface_write_data;
  logic code_storage_code_control_interface_reset;
  logic code_storage_code_control_interface_active;
  logic [31:0] fetch_to_decode_register_code_index_out_interface_code_index;
  logic [3:0] parse_0_op_interface_op;
  logic [3:0] parse_0_parameter_type_interface_dense_type;
  logic [3:0] parse_0_parameter_type_interface_act_type;
  logic [7:0] parse_0_parameter_type_interface_cost_type;
  modport slave (
    input code_storage_write_interface_is_write, code_storage_write_interface_write_line,
          code_storage_write_interface_write_data, code_storage_code_control_interface_reset,
          code_storage_code_control_interface_active,
    output fetch_to_decode_register_code_index_out_interface_code_index, parse_0_op_interface_op,
           parse_0_parameter_type_interface_dense_type, parse_0_parameter_type_interface_act_type,
           parse_0_parameter_type_interface_cost_type
  );
  modport master (
    output code_storage_write_interface_is_write, code_storage_write_interface_write_line,
           code_storage_write_interface_write_data, code_storage_code_control_interface_reset,
           code_storage_code_control_interface_active,
    input fetch_to_decode_register_code_index_out_interface_code_index, parse_0_op_interface_op,
          parse_0_parameter_type_interface_dense_type, parse_0_parameter_type_interface_act_type,
          parse_0_parameter_type_interface_cost_type
  );
endinterface

// File: rtl/code_data_path_code_storage.sv
// code_storage: CODE_DEPTH x 12 instruction memory, ranged write port (clk, rst_n, is_write, write_line, write_data), async read (rd_addr -> rd_data)
module code_storage
  import code_data_path_pkg::*;
#(
  parameter int CODE_DEPTH = 64,
  localparam int AW = $clog2(CODE_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic is_write,
  input  logic [31:0] write_line,
  input  logic [INSTR_W-1:0] write_data,
  input  logic [AW-1:0] rd_addr,
  output logic [INSTR_W-1:0] rd_data
);
  logic [INSTR_W-1:0] mem [CODE_DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < CODE_DEPTH; i++) mem[i] <= '0;
    else if (is_write && write_line < 32'(CODE_DEPTH))
      mem[write_line[AW-1:0]] <= write_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/code_data_path.sv
// code_data_path: code storage, fetch pc, fetch-to-decode register and parse; ports clk_clk, reset_reset_n, bus (code_data_path_if.slave); optional HALT via DP_HALT_OP_EN
module code_data_path
  import code_data_path_pkg::*;
#(
  parameter int CODE_DEPTH = 64,
  localparam int AW = $clog2(CODE_DEPTH)
) (
  input logic clk_clk,
  input logic reset_reset_n,
  code_data_path_if.slave bus
);
  logic [AW-1:0] pc;
  logic [INSTR_W-1:0] rd_data;
  f2d_t f2d;
  logic halt;
  logic [3:0] op;
  code_storage #(.CODE_DEPTH(CODE_DEPTH)) u_storage (
    .clk(clk_clk),
    .rst_n(reset_reset_n),
    .is_write(bus.code_storage_write_interface_is_write),
    .write_line(bus.code_storage_write_interface_write_line),
    .write_data(bus.code_storage_write_interface_write_data),
    .rd_addr(pc),
    .rd_data(rd_data)
  );
`ifdef DP_HALT_OP_EN
  assign halt = instr_op(f2d.instr) == OP_HALT;
`else
  assign halt = 1'b0;
`endif
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      pc <= '0;
      f2d <= '0;
    end else if (bus.code_storage_code_control_interface_reset) begin
      pc <= '0;
      f2d <= '0;
    end else if (bus.code_storage_code_control_interface_active && !halt) begin
      f2d <= '{code_index: 32'(pc), instr: rd_data};
      pc <= pc + 1'b1;
    end
  assign op = instr_op(f2d.instr);
  always_comb begin
    bus.fetch_to_decode_register_code_index_out_interface_code_index = f2d.code_index;
    bus.parse_0_op_interface_op = op;
    bus.parse_0_parameter_type_interface_dense_type = op == OP_DENSE ? instr_hi(f2d.instr) : 4'h0;
    bus.parse_0_parameter_type_interface_act_type = op == OP_DENSE ? instr_lo(f2d.instr) : 4'h0;
    bus.parse_0_parameter_type_interface_cost_type = op == OP_COST ? instr_byte(f2d.instr) : 8'h00;
  end
endmodule

// File: tb/tb_code_data_path.sv
// tb_code_data_path: directed self-checking bench for code_data_path
module tb_code_data_path;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  code_data_path_if bus ();
  code_data_path #(.CODE_DEPTH(64)) dut (.clk_clk(clk), .reset_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] idx, input logic [3:0] op,
                         input logic [3:0] dn, input logic [3:0] ac, input logic [7:0] co);
    chk({tag, ".index"}, bus.fetch_to_decode_register_code_index_out_interface_code_index, idx);
    chk({tag, ".op"}, 32'(bus.parse_0_op_interface_op), 32'(op));
    chk({tag, ".dense"}, 32'(bus.parse_0_parameter_type_interface_dense_type), 32'(dn));
    chk({tag, ".act"}, 32'(bus.parse_0_parameter_type_interface_act_type), 32'(ac));
    chk({tag, ".cost"}, 32'(bus.parse_0_parameter_type_interface_cost_type), 32'(co));
  endtask
  task automatic wr(input logic [31:0] line, input logic [11:0] data);
    bus.code_storage_write_interface_is_write = 1'b1;
    bus.code_storage_write_interface_write_line = line;
    bus.code_storage_write_interface_write_data = data;
    tick();
    bus.code_storage_write_interface_is_write = 1'b0;
  endtask
  task automatic ctrl_reset();
    bus.code_storage_code_control_interface_reset = 1'b1;
    tick();
    bus.code_storage_code_control_interface_reset = 1'b0;
  endtask
  initial begin
    bus.code_storage_write_interface_is_write = 1'b0;
    bus.code_storage_write_interface_write_line = '0;
    bus.code_storage_write_interface_write_data = '0;
    bus.code_storage_code_control_interface_reset = 1'b0;
    bus.code_storage_code_control_interface_active = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 4'h0, 4'h0, 4'h0, 8'h00);
    rst_n = 1'b1;
    wr(0, 12'h135);
    wr(1, 12'h207);
    wr(2, 12'h000);
    wr(63, 12'h2AB);
    bus.code_storage_code_control_interface_active = 1'b1;
    tick();
    chk_all("fetch0", 0, 4'h1, 4'h3, 4'h5, 8'h00);
    tick();
    chk_all("fetch1", 1, 4'h2, 4'h0, 4'h0, 8'h07);
    bus.code_storage_code_control_interface_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 1, 4'h2, 4'h0, 4'h0, 8'h07);
    end
    bus.code_storage_code_control_interface_active = 1'b1;
    tick();
    chk_all("resume2", 2, 4'h0, 4'h0, 4'h0, 8'h00);
    ctrl_reset();
    chk_all("ctrl_reset", 0, 4'h0, 4'h0, 4'h0, 8'h00);
    tick();
    chk_all("refetch0", 0, 4'h1, 4'h3, 4'h5, 8'h00);
    repeat (62) tick();
    chk("run62.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 62);
    tick();
    chk_all("line63", 63, 4'h2, 4'h0, 4'h0, 8'hAB);
    tick();
    chk_all("wrap", 0, 4'h1, 4'h3, 4'h5, 8'h00);
    bus.code_storage_code_control_interface_active = 1'b0;
    wr(64, 12'hFFF);
    ctrl_reset();
    bus.code_storage_code_control_interface_active = 1'b1;
    wr(0, 12'h1AA);
    chk_all("oob_and_rbw", 0, 4'h1, 4'h3, 4'h5, 8'h00);
    bus.code_storage_code_control_interface_active = 1'b0;
    ctrl_reset();
    bus.code_storage_code_control_interface_active = 1'b1;
    tick();
    chk_all("new_word", 0, 4'h1, 4'hA, 4'hA, 8'h00);
    bus.code_storage_code_control_interface_active = 1'b0;
    wr(1, 12'hF00);
    ctrl_reset();
    bus.code_storage_code_control_interface_active = 1'b1;
    tick();
    chk("halt_pre.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 0);
    tick();
    chk_all("op_f", 1, 4'hF, 4'h0, 4'h0, 8'h00);
    tick();
`ifdef DP_HALT_OP_EN
    chk("halt_a.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 1);
    tick();
    chk("halt_b.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 1);
`else
    chk("nohalt_a.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 2);
    tick();
    chk("nohalt_b.index", bus.fetch_to_decode_register_code_index_out_interface_code_index, 3);
`endif
    ctrl_reset();
    chk_all("halt_exit", 0, 4'h0, 4'h0, 4'h0, 8'h00);
    tick();
    chk_all("pre_async", 0, 4'h1, 4'hA, 4'hA, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 4'h0, 4'h0, 4'h0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("mem_cleared", 0, 4'h0, 4'h0, 4'h0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
